mult_err_accum: RTL and testbench
=================================

Name: mult_err_accum

Overview:
- Downstream error-statistics stage for the 8-bit approximate multipliers.
- Consumes operand pairs and the approximate product from the multiplier under test.
- Computes the exact product internally and accumulates error-distance statistics over a window of 2^LOG_N samples.
- Reports the results through a valid/ready handshake, for on-chip characterisation in place of offline real-valued error checks.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH bits.
- LOG_N, 8, window of 2^LOG_N accepted samples.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a new window (honoured only in IDLE).
- in_valid  in  1  sample present on a/b/y.
- in_ready  out  1  block accepts a sample this cycle.
- a  in  WIDTH  multiplier operand A.
- b  in  WIDTH  multiplier operand B.
- y  in  2*WIDTH  approximate product for (a,b).
- busy  out  1  high in COLLECT or DRAIN.
- out_valid  out  1  results valid; held until out_ready.
- out_ready  in  1  consumer takes results.
- sum_ed  out  2*WIDTH+LOG_N  sum of |y - a*b|.
- max_ed  out  2*WIDTH  largest error distance in the window.
- max_a  out  WIDTH  operand A of the first sample reaching max_ed.
- max_b  out  WIDTH  operand B of the first sample reaching max_ed.
- err_count  out  LOG_N+1  number of samples with nonzero error distance.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high, on ports clk and reset.
  - Reset, including mid-window, forces IDLE, clears the pipeline valids and sample counter, and drives every output to 0: in_ready, busy, out_valid and all result ports. Any partial window is discarded.
- FSM states: IDLE, COLLECT, DRAIN, REPORT.
  - IDLE: in_ready=0. start=1 clears the accumulators, sample counter and max registers, then goes to COLLECT. in_valid is ignored.
  - COLLECT: in_ready=1. A sample is accepted when in_valid & in_ready, and the counter increments. On the cycle the 2^LOG_N-th sample is accepted, go to DRAIN; in_ready=0 from the next cycle. start is ignored.
  - DRAIN: in_ready=0. Wait until pipeline stages S1 and S2 are both empty, which takes exactly 2 cycles after the last accept, then go to REPORT.
  - REPORT: out_valid=1 with all result ports stable. On out_ready=1, out_valid drops next cycle and the FSM goes to IDLE.
- Result retention: result ports keep their values in IDLE until the next start clears them.
- Pipeline:
  - S1 registers a, b, y and a valid bit.
  - S2 computes exact=a*b (2*WIDTH bits) and ed=|y-exact| using a 2*WIDTH+1-bit signed difference; registers ed, a, b and valid.
  - S3 updates the accumulators.
  - Latency is 2 cycles from accept to accumulator update. Throughput is 1 sample per cycle; no bubbles are required.
- Accumulation, on each S2-valid:
  - sum_ed += ed.
  - err_count += (ed != 0).
  - If ed > max_ed (strictly greater), load max_ed/max_a/max_b. Ties keep the earlier sample.
  - The first sample with ed=0 leaves max_a/max_b at 0.
- Widths guarantee no overflow: sum_ed max is (2^(2W)-1)*2^LOG_N, and err_count can reach 2^LOG_N.
- Boundaries:
  - in_valid gaps in COLLECT simply stall counting.
  - The sample counter rolls over only through the DRAIN transition.
  - start together with reset: reset wins.
  - start while out_valid=1 is ignored.

Optional Feature:
- Macro MULT_ERR_SQ_EN.
- Defined:
  - Adds output port sum_sq_ed, width 4*WIDTH+LOG_N, the sum of ed*ed over the window.
  - The square is computed in S2 alongside ed, so latency is unchanged.
  - The port is cleared on reset and start, and follows the same hold rules as sum_ed.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Exact multiplier, LOG_N=2: samples (3,5,15), (17,17,289), (255,255,65025), (0,19,0) -> sum_ed=0, max_ed=0, max_a=max_b=0, err_count=0; out_valid asserts 3 cycles after the 4th accept.
- Approximate errors, LOG_N=2: (255,255,65025), (17,17,280), (23,67,1536), (0,19,0) -> sum_ed=14, max_ed=9, max_a=17, max_b=17, err_count=2.
  - With MULT_ERR_SQ_EN: sum_sq_ed=106.
- Tie and overshoot: (17,17,298) then (3,3,0) -> both ed=9, max_a=17 retained; a y above the exact product yields a positive ed.
- Handshake: in_valid toggling every other cycle, with out_ready low for 5 cycles in REPORT -> exactly 2^LOG_N samples counted; out_valid and results are stable for all 5 cycles; IDLE the cycle after out_ready.
- Worst case, LOG_N=8: 256 samples of (255,255,0) -> sum_ed=16646400, max_ed=65025, err_count=256, no wrap.
- Reset mid-COLLECT after 2 samples, then start and 4 exact samples (LOG_N=2) -> all outputs 0 after reset; the new window reports sum_ed=0 and err_count=0.

Source files
------------

// File: rtl/mult_err_accum.sv
// mult_err_accum: error-distance statistics stage for approximate multipliers.
// Each window takes 2^LOG_N operand/product samples. For every sample the block
// computes the exact product a*b and ed = |y - a*b|. It accumulates the sum of
// ed, the count of nonzero ed, and the largest ed together with the operands
// that first reached it. Results are offered through out_valid/out_ready.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              begins a new window (only honoured in IDLE)
//   in_valid/in_ready  sample handshake for a, b, y
//   a, b               operands (WIDTH bits)
//   y                  approximate product (2*WIDTH bits)
//   busy               high while collecting or draining the pipeline
//   out_valid/ready    result handshake; results are held until taken
//   sum_ed, max_ed, max_a, max_b, err_count   window statistics
//   sum_sq_ed          sum of ed*ed (only when MULT_ERR_SQ_EN is defined)
//
// Optional feature macro: MULT_ERR_SQ_EN adds the sum_sq_ed output.
module mult_err_accum #(
  parameter int WIDTH = 8,
  parameter int LOG_N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2*WIDTH-1:0]       y,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH+LOG_N-1:0] sum_ed,
  output logic [2*WIDTH-1:0]       max_ed,
  output logic [WIDTH-1:0]         max_a,
  output logic [WIDTH-1:0]         max_b,
  output logic [LOG_N:0]           err_count
`ifdef MULT_ERR_SQ_EN
  ,
  output logic [4*WIDTH+LOG_N-1:0] sum_sq_ed
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, REPORT} state_t;

  state_t           state;
  logic [LOG_N-1:0] cnt;
  logic             accept;

  // S1 registers
  logic               s1_v;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [2*WIDTH-1:0] s1_y;

  // S2 combinational error computation
  logic [2*WIDTH-1:0]        exact;
  logic signed [2*WIDTH:0]   diff;
  logic signed [2*WIDTH:0]   ndiff;
  logic [2*WIDTH-1:0]        ed_c;

  // S2 registers
  logic               s2_v;
  logic [WIDTH-1:0]   s2_a, s2_b;
  logic [2*WIDTH-1:0] s2_ed;

`ifdef MULT_ERR_SQ_EN
  logic [4*WIDTH-1:0] sq_c;
  logic [4*WIDTH-1:0] s2_sq;
`endif

  assign accept = in_valid & in_ready;

  assign exact = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
  // One extra bit keeps the sign of y - exact so overshoot and undershoot
  // both produce a positive distance.
  assign diff  = $signed({1'b0, s1_y}) - $signed({1'b0, exact});
  assign ndiff = -diff;
  assign ed_c  = diff[2*WIDTH] ? ndiff[2*WIDTH-1:0] : diff[2*WIDTH-1:0];

`ifdef MULT_ERR_SQ_EN
  assign sq_c = {{2*WIDTH{1'b0}}, ed_c} * {{2*WIDTH{1'b0}}, ed_c};
`endif

  // Pipeline stages S1 and S2
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
    if (accept) begin
      s1_a <= a;
      s1_b <= b;
      s1_y <= y;
    end
    if (s1_v) begin
      s2_a  <= s1_a;
      s2_b  <= s1_b;
      s2_ed <= ed_c;
`ifdef MULT_ERR_SQ_EN
      s2_sq <= sq_c;
`endif
    end
  end

  // Control FSM and S3 accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sum_ed    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
      err_count <= '0;
`ifdef MULT_ERR_SQ_EN
      sum_sq_ed <= '0;
`endif
    end else begin
      if (s2_v) begin
        sum_ed    <= sum_ed + {{LOG_N{1'b0}}, s2_ed};
        err_count <= err_count + {{LOG_N{1'b0}}, (s2_ed != '0)};
`ifdef MULT_ERR_SQ_EN
        sum_sq_ed <= sum_sq_ed + {{LOG_N{1'b0}}, s2_sq};
`endif
        // Strictly greater: on ties the earlier sample keeps its operands.
        if (s2_ed > max_ed) begin
          max_ed <= s2_ed;
          max_a  <= s2_a;
          max_b  <= s2_b;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
            err_count <= '0;
`ifdef MULT_ERR_SQ_EN
            sum_sq_ed <= '0;
`endif
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_v && !s2_v) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_err_accum.sv
// Scoreboard bench for mult_err_accum: a LOG_N=2 instance for the window,
// handshake and reset cases, and a LOG_N=8 instance for the worst-case window.
module tb_mult_err_accum;
  localparam int W   = 8;
  localparam int LN  = 2;
  localparam int LN8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, in_valid, in_ready, busy, out_valid, out_ready;
  logic [W-1:0]       a, b, max_a, max_b;
  logic [2*W-1:0]     y, max_ed;
  logic [2*W+LN-1:0]  sum_ed;
  logic [LN:0]        err_count;

  logic               w_start, w_in_valid, w_in_ready, w_busy, w_out_valid, w_out_ready;
  logic [W-1:0]       w_a, w_b, w_max_a, w_max_b;
  logic [2*W-1:0]     w_y, w_max_ed;
  logic [2*W+LN8-1:0] w_sum_ed;
  logic [LN8:0]       w_err_count;

`ifdef MULT_ERR_SQ_EN
  logic [4*W+LN-1:0]  sum_sq_ed;
  logic [4*W+LN8-1:0] w_sum_sq_ed;
`endif

  mult_err_accum #(.WIDTH(W), .LOG_N(LN)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .y(y), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .sum_ed(sum_ed),
    .max_ed(max_ed), .max_a(max_a), .max_b(max_b), .err_count(err_count)
`ifdef MULT_ERR_SQ_EN
    , .sum_sq_ed(sum_sq_ed)
`endif
  );

  mult_err_accum #(.WIDTH(W), .LOG_N(LN8)) dut8 (
    .clk(clk), .reset(reset), .start(w_start), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .a(w_a), .b(w_b), .y(w_y), .busy(w_busy),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .sum_ed(w_sum_ed),
    .max_ed(w_max_ed), .max_a(w_max_a), .max_b(w_max_b), .err_count(w_err_count)
`ifdef MULT_ERR_SQ_EN
    , .sum_sq_ed(w_sum_sq_ed)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] sum, mx, ma, mb, ec, sq;
  } res_t;

  res_t        sb[$];
  int unsigned win_a[$], win_b[$], win_y[$];

  task automatic add(input int unsigned sa, input int unsigned sb_, input int unsigned sy);
    win_a.push_back(sa);
    win_b.push_back(sb_);
    win_y.push_back(sy);
  endtask

  task automatic clear_win();
    win_a.delete();
    win_b.delete();
    win_y.delete();
  endtask

  // Reference statistics computed directly from the sample list.
  function automatic res_t model();
    res_t r;
    longint unsigned ex, ed;
    r.sum = 0; r.mx = 0; r.ma = 0; r.mb = 0; r.ec = 0; r.sq = 0;
    for (int i = 0; i < win_a.size(); i++) begin
      ex = longint'(win_a[i]) * longint'(win_b[i]);
      ed = (longint'(win_y[i]) > ex) ? longint'(win_y[i]) - ex : ex - longint'(win_y[i]);
      r.sum = r.sum + ed;
      r.sq  = r.sq + ed * ed;
      if (ed != 0) r.ec = r.ec + 1;
      if (ed > r.mx) begin
        r.mx = ed;
        r.ma = 64'(win_a[i]);
        r.mb = 64'(win_b[i]);
      end
    end
    return r;
  endfunction

  task automatic check_results(input string tag, input res_t e);
    check({tag, ".sum_ed"},    64'(sum_ed),    e.sum);
    check({tag, ".max_ed"},    64'(max_ed),    e.mx);
    check({tag, ".max_a"},     64'(max_a),     e.ma);
    check({tag, ".max_b"},     64'(max_b),     e.mb);
    check({tag, ".err_count"}, 64'(err_count), e.ec);
`ifdef MULT_ERR_SQ_EN
    check({tag, ".sum_sq_ed"}, 64'(sum_sq_ed), e.sq);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    res_t z;
    z.sum = 0; z.mx = 0; z.ma = 0; z.mb = 0; z.ec = 0; z.sq = 0;
    check({tag, ".in_ready"},  64'(in_ready),  64'd0);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check_results(tag, z);
  endtask

  // Runs one window on the LOG_N=2 instance: push expectation, drive samples,
  // pop and compare on out_valid, hold out_ready low for 'hold' cycles.
  task automatic run_window(input string tag, input bit gaps, input int hold);
    res_t e;
    int   i = 0;
    int   guard = 0;
    int   lat = 0;
    bit   tog = 1'b0;
    sb.push_back(model());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, ".busy_on"}, 64'(busy), 64'd1);
    while (i < win_a.size() && guard < 200) begin
      tog = gaps ? ~tog : 1'b1;
      if (tog && in_ready) begin
        a = W'(win_a[i]); b = W'(win_b[i]); y = (2*W)'(win_y[i]);
        in_valid = 1'b1;
        i++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check({tag, ".accepted"}, 64'(i), 64'(win_a.size()));
    check({tag, ".rdy_drop"}, 64'(in_ready), 64'd0);
    // Junk offered while in_ready is low must not be counted.
    a = 8'd200; b = 8'd200; y = '0; in_valid = 1'b1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".latency"},   64'(lat),       64'd3);
    check({tag, ".busy_rep"},  64'(busy),      64'd0);
    e = sb.pop_front();
    check_results(tag, e);
    for (int k = 0; k < hold; k++) begin
      start = (k == 0);
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_busy"},  64'(busy),      64'd0);
      check_results({tag, ".hold"}, e);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_rdy"},   64'(in_ready),  64'd0);
    check({tag, ".idle_busy"},  64'(busy),      64'd0);
    check_results({tag, ".retain"}, e);
  endtask

  initial begin
    res_t e;
    int   acc;
    int   guard;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; y = '0;
    w_start = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    w_a = '0; w_b = '0; w_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // start together with reset: reset wins
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_all_zero("rst_start");

    clear_win();
    add(3, 5, 15); add(17, 17, 289); add(255, 255, 65025); add(0, 19, 0);
    run_window("exact", 1'b0, 0);

    clear_win();
    add(255, 255, 65025); add(17, 17, 280); add(23, 67, 1536); add(0, 19, 0);
    run_window("approx", 1'b0, 1);

    clear_win();
    add(17, 17, 298); add(3, 3, 0); add(5, 5, 25); add(2, 2, 4);
    run_window("tie", 1'b0, 0);

    clear_win();
    add(12, 34, 400); add(200, 3, 600); add(9, 9, 90); add(255, 1, 250);
    run_window("handshake", 1'b1, 5);

    for (int r = 0; r < 3; r++) begin
      clear_win();
      for (int s = 0; s < 4; s++) begin
        int unsigned ra = $urandom_range(0, 255);
        int unsigned rb = $urandom_range(0, 255);
        int unsigned ry = ($urandom_range(0, 3) == 0) ? ra * rb : $urandom_range(0, 65535);
        add(ra, rb, ry);
      end
      run_window($sformatf("rand%0d", r), r[0], 1);
    end

    // Reset in the middle of a window discards it
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    a = 8'd17; b = 8'd17; y = 16'd280; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd3; b = 8'd3; y = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({"midrst.partial"}, 64'(sum_ed), 64'd9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midrst");
    clear_win();
    add(1, 1, 1); add(2, 3, 6); add(100, 100, 10000); add(7, 0, 0);
    run_window("post_rst", 1'b0, 0);

    // Worst case on the LOG_N=8 instance
    clear_win();
    for (int s = 0; s < 256; s++) add(255, 255, 0);
    sb.push_back(model());
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    w_a = 8'd255; w_b = 8'd255; w_y = '0;
    acc = 0; guard = 0;
    while (acc < 256 && guard < 400) begin
      w_in_valid = 1'b1;
      if (w_in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    w_in_valid = 1'b0;
    check("wide.accepted", 64'(acc), 64'd256);
    guard = 0;
    while (!w_out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wide.out_valid", 64'(w_out_valid), 64'd1);
    e = sb.pop_front();
    check("wide.sum_ed",    64'(w_sum_ed),    e.sum);
    check("wide.max_ed",    64'(w_max_ed),    e.mx);
    check("wide.max_a",     64'(w_max_a),     e.ma);
    check("wide.max_b",     64'(w_max_b),     e.mb);
    check("wide.err_count", 64'(w_err_count), e.ec);
`ifdef MULT_ERR_SQ_EN
    check("wide.sum_sq_ed", 64'(w_sum_sq_ed), e.sq);
`endif
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    check("wide.idle_valid", 64'(w_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
